fp_div_issue_ctrl: RTL and testbench

- Issue/capture controller directly upstream and downstream of the single-precision divider (FP_divider_SP).
- Accepts operand pairs over a valid/ready handshake and drives them onto the divider inputs. Holds those inputs stable for a fixed DIV_LATENCY cycles, because the divider's special-case flags are combinational on its operands.
- Captures the divider's quotient and flags into an output register with valid/ready back-pressure, and accumulates sticky exception flags.

---
 rtl/fp_div_pkg.sv | 18 +
 rtl/fp_div_issue_ctrl.sv | 131 +++++++++++++
 tb/tb_fp_div_issue_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_div_pkg.sv
// Shared types and constants for the single-precision divider issue path.
// State encoding and flag bit positions used by the controller and its users.
package fp_div_pkg;

    localparam int SP_W = 32;

    localparam int FLG_NAN  = 3;
    localparam int FLG_INF  = 2;
    localparam int FLG_ZERO = 1;
    localparam int FLG_SUB  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/fp_div_issue_ctrl.sv
// Launches operand pairs into the SP divider, holds them for the fixed latency,
// then captures quotient/flags into a back-pressured output register.
module fp_div_issue_ctrl
    import fp_div_pkg::*;
#(
    parameter int DIV_LATENCY = 38
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SP_W-1:0] in_op1,
    input  logic [SP_W-1:0] in_op2,
    output logic [SP_W-1:0] div_op1,
    output logic [SP_W-1:0] div_op2,
    input  logic [SP_W-1:0] div_quotient,
    input  logic            div_nan,
    input  logic            div_inf,
    input  logic            div_zero,
    input  logic            div_subnormal,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SP_W-1:0] out_quotient,
    output logic [3:0]      out_flags,
    output logic [3:0]      sticky_flags,
    input  logic            sticky_clr,
    output logic            busy
);

    localparam int CNT_W = $clog2(DIV_LATENCY + 1);

    div_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SP_W-1:0] op1_q, op1_d;
    logic [SP_W-1:0] op2_q, op2_d;
    logic [SP_W-1:0] quot_q, quot_d;
    logic [3:0]      flags_q, flags_d;
    logic [3:0]      sticky_q, sticky_d;
    logic            ovalid_q, ovalid_d;
    logic            capture;
    logic [3:0]      new_flags;

    always_comb begin
        new_flags          = '0;
        new_flags[FLG_NAN]  = div_nan;
        new_flags[FLG_INF]  = div_inf;
        new_flags[FLG_ZERO] = div_zero;
        new_flags[FLG_SUB]  = div_subnormal;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        quot_d   = quot_q;
        flags_d  = flags_q;
        ovalid_d = ovalid_q;
        capture  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op1_d   = in_op1;
                    op2_d   = in_op2;
                    cnt_d   = CNT_W'(DIV_LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    capture  = 1'b1;
                    quot_d   = div_quotient;
                    flags_d  = new_flags;
                    ovalid_d = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    ovalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A capture coinciding with a clear must still leave its flags behind.
    always_comb begin
        sticky_d = sticky_q;
        if (capture) begin
            sticky_d = (sticky_clr ? 4'b0 : sticky_q) | new_flags;
        end else if (sticky_clr) begin
            sticky_d = 4'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            quot_q   <= '0;
            flags_q  <= '0;
            sticky_q <= '0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            quot_q   <= quot_d;
            flags_q  <= flags_d;
            sticky_q <= sticky_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign busy         = !in_ready;
    assign div_op1      = op1_q;
    assign div_op2      = op2_q;
    assign out_valid    = ovalid_q;
    assign out_quotient = quot_q;
    assign out_flags    = flags_q;
    assign sticky_flags = sticky_q;

endmodule

// File: tb/tb_fp_div_issue_ctrl.sv
// Directed bench for fp_div_issue_ctrl with a 38-cycle divider model.
// Scenario tasks each do their own inline comparisons.
module tb_fp_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_op1;
    logic [31:0] in_op2;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic [31:0] div_quotient;
    logic        div_nan;
    logic        div_inf;
    logic        div_zero;
    logic        div_subnormal;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_quotient;
    logic [3:0]  out_flags;
    logic [3:0]  sticky_flags;
    logic        sticky_clr;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_div_issue_ctrl #(.DIV_LATENCY(38)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op1       (in_op1),
        .in_op2       (in_op2),
        .div_op1      (div_op1),
        .div_op2      (div_op2),
        .div_quotient (div_quotient),
        .div_nan      (div_nan),
        .div_inf      (div_inf),
        .div_zero     (div_zero),
        .div_subnormal(div_subnormal),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quotient (out_quotient),
        .out_flags    (out_flags),
        .sticky_flags (sticky_flags),
        .sticky_clr   (sticky_clr),
        .busy         (busy)
    );

    // Divider model: lookup table of known results, delayed so that the
    // result of operands launched at E0 is presented for sampling at E0+38.
    function automatic logic [35:0] div_lut(input logic [31:0] a,
                                            input logic [31:0] b);
        logic [35:0] r;
        r = 36'h0;
        if (a == 32'h40C00000 && b == 32'h40000000) r = {4'b0000, 32'h40400000};
        if (a == 32'h3F800000 && b == 32'h00000000) r = {4'b0100, 32'h7F800000};
        if (a == 32'h40800000 && b == 32'h40000000) r = {4'b0000, 32'h40000000};
        if (a == 32'h00000000 && b == 32'h00000000) r = {4'b1000, 32'h7FC00000};
        return r;
    endfunction

    logic [35:0] pipe [37];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 37; i++) pipe[i] <= 36'h0;
        end else begin
            pipe[0] <= div_lut(div_op1, div_op2);
            for (int i = 1; i < 37; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign div_quotient  = pipe[36][31:0];
    assign div_nan       = pipe[36][35];
    assign div_inf       = pipe[36][34];
    assign div_zero      = pipe[36][33];
    assign div_subnormal = pipe[36][32];

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_op1   = a;
        in_op2   = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic out_hs();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_op1     = 32'h12345678;
        in_op2     = 32'h9ABCDEF0;
        out_ready  = 1'b0;
        sticky_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || div_op1 !== 32'h0 ||
            div_op2 !== 32'h0 || out_quotient !== 32'h0 ||
            out_flags !== 4'h0 || sticky_flags !== 4'h0) begin
            errors++;
            $display("FAIL reset_regs: ov=%b busy=%b op1=%h op2=%h q=%h f=%b s=%b, want all 0",
                     out_valid, busy, div_op1, div_op2, out_quotient, out_flags, sticky_flags);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (div_op1 !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL no_sample_without_hs: op1=%h busy=%b want 0/0", div_op1, busy);
        end
    endtask

    task automatic test_basic();
        int n;
        bit rdy_err;
        launch(32'h40C00000, 32'h40000000);
        checks++;
        if (div_op1 !== 32'h40C00000 || div_op2 !== 32'h40000000) begin
            errors++;
            $display("FAIL basic_launch: op1=%h op2=%h want 40c00000/40000000",
                     div_op1, div_op2);
        end
        n = 0;
        rdy_err = 0;
        while (!out_valid && n < 100) begin
            if (in_ready !== 1'b0) rdy_err = 1;
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 38) begin
            errors++;
            $display("FAIL basic_latency: got %0d edges want 38", n);
        end
        checks++;
        if (rdy_err || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_in_ready_low: got high during op, want 0");
        end
        checks++;
        if (out_quotient !== 32'h40400000 || out_flags !== 4'b0000) begin
            errors++;
            $display("FAIL basic_result: q=%h f=%b want 40400000/0000",
                     out_quotient, out_flags);
        end
        out_hs();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_handshake: ov=%b rdy=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_div_by_zero();
        int n;
        launch(32'h3F800000, 32'h00000000);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 38 || out_quotient !== 32'h7F800000 || out_flags !== 4'b0100) begin
            errors++;
            $display("FAIL div_zero_result: n=%0d q=%h f=%b want 38/7f800000/0100",
                     n, out_quotient, out_flags);
        end
        checks++;
        if (sticky_flags !== 4'b0100) begin
            errors++;
            $display("FAIL div_zero_sticky: got %b want 0100", sticky_flags);
        end
        out_hs();
    endtask

    task automatic test_backpressure();
        int n;
        bit hold_err;
        launch(32'h40C00000, 32'h40000000);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_op1   = 32'h40800000;
        in_op2   = 32'h40000000;
        hold_err = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || out_quotient !== 32'h40400000 ||
                out_flags !== 4'b0000 || div_op1 !== 32'h40C00000 ||
                div_op2 !== 32'h40000000 || in_ready !== 1'b0) hold_err = 1;
        end
        checks++;
        if (hold_err) begin
            errors++;
            $display("FAIL bp_hold: q=%h f=%b op1=%h ov=%b want 40400000/0000/40c00000/1",
                     out_quotient, out_flags, div_op1, out_valid);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || div_op1 !== 32'h40C00000) begin
            errors++;
            $display("FAIL bp_handshake_edge: ov=%b rdy=%b op1=%h want 0/1/40c00000",
                     out_valid, in_ready, div_op1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (div_op1 !== 32'h40800000 || div_op2 !== 32'h40000000 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_accept: op1=%h op2=%h rdy=%b want 40800000/40000000/0",
                     div_op1, div_op2, in_ready);
        end
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 38 || out_quotient !== 32'h40000000 || out_flags !== 4'b0000) begin
            errors++;
            $display("FAIL bp_second_result: n=%0d q=%h f=%b want 38/40000000/0000",
                     n, out_quotient, out_flags);
        end
        out_hs();
    endtask

    task automatic test_sticky_clr_capture();
        launch(32'h00000000, 32'h00000000);
        repeat (37) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL nan_early: out_valid=%b at edge 37 want 0", out_valid);
        end
        @(negedge clk);
        sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        sticky_clr = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_flags !== 4'b1000 || out_quotient !== 32'h7FC00000) begin
            errors++;
            $display("FAIL nan_result: ov=%b f=%b q=%h want 1/1000/7fc00000",
                     out_valid, out_flags, out_quotient);
        end
        checks++;
        if (sticky_flags !== 4'b1000) begin
            errors++;
            $display("FAIL sticky_clr_on_capture: got %b want 1000", sticky_flags);
        end
        out_hs();
    endtask

    task automatic test_reset_mid_wait();
        int n;
        bit seen;
        launch(32'h40C00000, 32'h40000000);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 ||
            sticky_flags !== 4'b0000 || div_op1 !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_state: busy=%b rdy=%b ov=%b s=%b op1=%h want 0/1/0/0000/0",
                     busy, in_ready, out_valid, sticky_flags, div_op1);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) seen = 1;
        end
        checks++;
        if (seen || in_ready !== 1'b1 || sticky_flags !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_quiet: seen_valid=%b rdy=%b s=%b want 0/1/0000",
                     seen, in_ready, sticky_flags);
        end
        launch(32'h40C00000, 32'h40000000);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 38 || out_quotient !== 32'h40400000) begin
            errors++;
            $display("FAIL mid_reset_rerun: n=%0d q=%h want 38/40400000", n, out_quotient);
        end
        out_hs();
    endtask

    task automatic test_sticky_clr_idle();
        launch(32'h3F800000, 32'h00000000);
        repeat (38) @(posedge clk);
        #1;
        out_hs();
        checks++;
        if (sticky_flags !== 4'b0100) begin
            errors++;
            $display("FAIL sticky_accum: got %b want 0100", sticky_flags);
        end
        @(negedge clk);
        sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        sticky_clr = 1'b0;
        checks++;
        if (sticky_flags !== 4'b0000 || out_flags !== 4'b0100) begin
            errors++;
            $display("FAIL sticky_clr_idle: s=%b f=%b want 0000/0100",
                     sticky_flags, out_flags);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_by_zero();
        test_backpressure();
        test_sticky_clr_capture();
        test_reset_mid_wait();
        test_sticky_clr_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
